// File: rtl/sm_motion_ctrl.sv
// Motion controller feeding the stepper pulse stage: period word, load strobe, run enable.
// Latency: fixed period at go+1 with enable at go+2; ADC period at d_v+2 with enable one cycle after the first load.
// No backpressure: strobes are one cycle wide, and AUTO samples outside AUTO or during a stop are dropped.
module sm_motion_ctrl #(
  parameter int SIZE      = 16,
  parameter int ADC_W     = 12,
  parameter int ADC_SHIFT = 0,
  parameter int P_MIN     = 16,
  parameter int P_MAX     = 4000,
  parameter int P_FIX     = 400
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_v,
  input  logic [ADC_W-1:0] adc_data,
  input  logic [1:0]       mode,
  input  logic             cmd_go,
  input  logic             cmd_stop,
  input  logic [SIZE-1:0]  n_steps,
  input  logic             drv_step,
  output logic [SIZE-1:0]  n,
  output logic             n_v,
  output logic             drv_en_SM,
  output logic             busy,
  output logic             done,
  output logic [SIZE-1:0]  step_cnt
);

  localparam logic [SIZE-1:0] PMIN_W = SIZE'(P_MIN);
  localparam logic [SIZE-1:0] PMAX_W = SIZE'(P_MAX);
  localparam logic [SIZE-1:0] PFIX_W = SIZE'(P_FIX);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_AUTO  = 2'd1,
    ST_MOVE  = 2'd2,
    ST_MOVEN = 2'd3
  } state_t;

  state_t          state_q;
  logic [SIZE-1:0] n_q;
  logic            n_v_q;
  logic            drv_en_q;
  logic            busy_q;
  logic            done_q;
  logic [SIZE-1:0] step_cnt_q;
  logic [SIZE-1:0] target_q;
  logic            step_prev_q;
  logic [SIZE-1:0] s_q;
  logic            s_vld_q;

  logic [ADC_W-1:0] adc_sh;
  logic [SIZE:0]    p_raw;
  logic [SIZE-1:0]  p_clamp;
  logic             go_ok;
  logic             step_edge;
  logic [SIZE-1:0]  cnt_inc;
  logic             last_step;

  // Period map, step-edge detection and go qualification
  always_comb begin
    adc_sh    = adc_data >> ADC_SHIFT;
    // One extra bit so an ADC value above P_MAX shows up as a negative period
    p_raw     = {1'b0, PMAX_W} - {1'b0, s_q};
    p_clamp   = (p_raw[SIZE] || (p_raw[SIZE-1:0] < PMIN_W)) ? PMIN_W : p_raw[SIZE-1:0];
    go_ok     = (state_q == ST_STOP) && cmd_go && !cmd_stop && (mode != 2'b11);
    step_edge = drv_step && !step_prev_q && drv_en_q;
    cnt_inc   = (&step_cnt_q) ? step_cnt_q : step_cnt_q + SIZE'(1);
    last_step = (state_q == ST_MOVEN) && step_edge && (cnt_inc == target_q);
  end

  // Step counter: rising edges of the returned step pulse while enabled, cleared on go
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_prev_q <= 1'b0;
      step_cnt_q  <= '0;
    end else begin
      step_prev_q <= drv_step;
      if (go_ok) begin
        step_cnt_q <= '0;
      end else if (step_edge) begin
        step_cnt_q <= cnt_inc;
      end
    end
  end

  // First AUTO stage: capture the shifted sample; a stop cycle kills it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q     <= '0;
      s_vld_q <= 1'b0;
    end else begin
      s_vld_q <= d_v && (state_q == ST_AUTO) && !cmd_stop;
      if (d_v) begin
        s_q <= SIZE'(adc_sh);
      end
    end
  end

  // Mode FSM with registered period, strobes, enable and status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_STOP;
      n_q      <= PMAX_W;
      n_v_q    <= 1'b0;
      drv_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      target_q <= '0;
    end else begin
      n_v_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_STOP: begin
          drv_en_q <= 1'b0;
          if (go_ok) begin
            target_q <= n_steps;
            case (mode)
              2'b00: begin
                state_q <= ST_AUTO;
                busy_q  <= 1'b1;
              end
              2'b01: begin
                state_q <= ST_MOVE;
                busy_q  <= 1'b1;
                n_q     <= PFIX_W;
                n_v_q   <= 1'b1;
              end
              default: begin
                // A zero target completes immediately without ever running
                if (n_steps == '0) begin
                  done_q <= 1'b1;
                end else begin
                  state_q <= ST_MOVEN;
                  busy_q  <= 1'b1;
                  n_q     <= PFIX_W;
                  n_v_q   <= 1'b1;
                end
              end
            endcase
          end
        end
        ST_AUTO: begin
          if (cmd_stop) begin
            state_q  <= ST_STOP;
            busy_q   <= 1'b0;
            drv_en_q <= 1'b0;
          end else begin
            if (s_vld_q) begin
              n_q   <= p_clamp;
              n_v_q <= 1'b1;
            end
            // Enable only after a fresh period has been loaded
            if (n_v_q) begin
              drv_en_q <= 1'b1;
            end
          end
        end
        ST_MOVE: begin
          if (cmd_stop) begin
            state_q  <= ST_STOP;
            busy_q   <= 1'b0;
            drv_en_q <= 1'b0;
          end else if (n_v_q) begin
            drv_en_q <= 1'b1;
          end
        end
        default: begin
          // The final step takes priority over a coincident stop so done still fires
          if (last_step) begin
            state_q  <= ST_STOP;
            busy_q   <= 1'b0;
            drv_en_q <= 1'b0;
            done_q   <= 1'b1;
          end else if (cmd_stop) begin
            state_q  <= ST_STOP;
            busy_q   <= 1'b0;
            drv_en_q <= 1'b0;
          end else if (n_v_q) begin
            drv_en_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign n         = n_q;
  assign n_v       = n_v_q;
  assign drv_en_SM = drv_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign step_cnt  = step_cnt_q;

endmodule

// File: tb/tb_sm_motion_ctrl.sv
// Directed-sequence bench for sm_motion_ctrl with randomized samples and step targets.
// Expected periods come from the arithmetic period map; timing expectations are fixed offsets.
module tb_sm_motion_ctrl;

  localparam int SIZE      = 16;
  localparam int ADC_W     = 12;
  localparam int ADC_SHIFT = 0;
  localparam int P_MIN     = 16;
  localparam int P_MAX     = 4000;
  localparam int P_FIX     = 400;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             d_v = 1'b0;
  logic [ADC_W-1:0] adc_data = '0;
  logic [1:0]       mode = 2'b00;
  logic             cmd_go = 1'b0;
  logic             cmd_stop = 1'b0;
  logic [SIZE-1:0]  n_steps = '0;
  logic             drv_step = 1'b0;
  logic [SIZE-1:0]  n;
  logic             n_v;
  logic             drv_en_SM;
  logic             busy;
  logic             done;
  logic [SIZE-1:0]  step_cnt;

  int vectors = 0;
  int miscompares = 0;
  int samp[5];

  sm_motion_ctrl #(
    .SIZE(SIZE), .ADC_W(ADC_W), .ADC_SHIFT(ADC_SHIFT),
    .P_MIN(P_MIN), .P_MAX(P_MAX), .P_FIX(P_FIX)
  ) dut (
    .clk(clk), .rst(rst), .d_v(d_v), .adc_data(adc_data), .mode(mode),
    .cmd_go(cmd_go), .cmd_stop(cmd_stop), .n_steps(n_steps), .drv_step(drv_step),
    .n(n), .n_v(n_v), .drv_en_SM(drv_en_SM), .busy(busy), .done(done),
    .step_cnt(step_cnt)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Period the pulse stage should receive for a raw ADC sample
  function automatic int pmap(input int adc);
    int p;
    p = P_MAX - (adc >> ADC_SHIFT);
    if (p < P_MIN) p = P_MIN;
    return p;
  endfunction

  task automatic go(input logic [1:0] m, input logic [SIZE-1:0] ns);
    mode    = m;
    n_steps = ns;
    cmd_go  = 1'b1;
    tick();
    cmd_go  = 1'b0;
  endtask

  task automatic run_moven(input int tgt, input bit stop_on_last, input string tag);
    int exp_cnt;
    go(2'b10, SIZE'(tgt));
    chk({tag, " nv_go1"}, n_v, 1);
    chk({tag, " n_go1"}, n, P_FIX);
    chk({tag, " busy_go1"}, busy, 1);
    chk({tag, " en_go1"}, drv_en_SM, 0);
    tick();
    chk({tag, " en_go2"}, drv_en_SM, 1);
    for (int k = 1; k <= tgt + 1; k++) begin
      drv_step = 1'b1;
      if (stop_on_last && k == tgt) cmd_stop = 1'b1;
      tick();
      drv_step = 1'b0;
      cmd_stop = 1'b0;
      exp_cnt = (k <= tgt) ? k : tgt;
      chk({tag, " cnt"}, step_cnt, exp_cnt);
      chk({tag, " done"}, done, (k == tgt) ? 1 : 0);
      chk({tag, " en"}, drv_en_SM, (k < tgt) ? 1 : 0);
      chk({tag, " busy"}, busy, (k < tgt) ? 1 : 0);
      tick();
      chk({tag, " done_off"}, done, 0);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    // Reset values
    #25;
    chk("rst n", n, P_MAX);
    chk("rst nv", n_v, 0);
    chk("rst en", drv_en_SM, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst cnt", step_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // AUTO: no enable before the first period, then adc 1000 -> 3000 at d_v+2
    go(2'b00, '0);
    chk("auto busy", busy, 1);
    chk("auto nv0", n_v, 0);
    tick();
    tick();
    chk("auto no_stale_en", drv_en_SM, 0);
    d_v = 1'b1;
    adc_data = 12'd1000;
    tick();
    d_v = 1'b0;
    chk("auto nv_t1", n_v, 0);
    tick();
    chk("auto nv_t2", n_v, 1);
    chk("auto n_t2", n, pmap(1000));
    chk("auto en_t2", drv_en_SM, 0);
    tick();
    chk("auto en_t3", drv_en_SM, 1);
    chk("auto nv_t3", n_v, 0);

    // Back-to-back samples including the clamp boundary
    samp[0] = 4095;
    samp[1] = 3985;
    samp[2] = 3984;
    samp[3] = int'($urandom_range(0, 4095));
    samp[4] = int'($urandom_range(0, 4095));
    for (int c = 0; c < 8; c++) begin
      if (c < 5) begin
        d_v = 1'b1;
        adc_data = ADC_W'(samp[c]);
      end else begin
        d_v = 1'b0;
      end
      tick();
      if (c >= 1 && c <= 5) begin
        chk("b2b nv", n_v, 1);
        chk("b2b n", n, pmap(samp[c-1]));
      end else begin
        chk("b2b nv_idle", n_v, 0);
      end
    end
    chk("b2b en", drv_en_SM, 1);
    cmd_stop = 1'b1;
    tick();
    cmd_stop = 1'b0;
    chk("stop busy", busy, 0);
    chk("stop en", drv_en_SM, 0);
    chk("stop done", done, 0);
    chk("stop n_kept", n, pmap(samp[4]));

    // d_v during MOVE is dropped
    go(2'b01, '0);
    chk("move nv", n_v, 1);
    chk("move n", n, P_FIX);
    d_v = 1'b1;
    adc_data = ADC_W'($urandom_range(0, 4095));
    tick();
    d_v = 1'b0;
    chk("move en", drv_en_SM, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("move dv_nv", n_v, 0);
      chk("move dv_n", n, P_FIX);
    end
    cmd_stop = 1'b1;
    tick();
    cmd_stop = 1'b0;

    // Sample in flight when stop arrives is dropped
    go(2'b00, '0);
    d_v = 1'b1;
    adc_data = 12'd100;
    tick();
    cmd_stop = 1'b1;
    adc_data = 12'd200;
    tick();
    d_v = 1'b0;
    cmd_stop = 1'b0;
    chk("flight busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      chk("flight nv", n_v, 0);
      chk("flight n", n, P_FIX);
      tick();
    end

    // MOVE_N runs: fixed, random target, stop on the final edge
    run_moven(5, 1'b0, "mn5");
    run_moven(int'($urandom_range(1, 6)), 1'b0, "mnr");
    run_moven(3, 1'b1, "mnstop");

    // Zero target completes at go+1
    go(2'b10, '0);
    chk("zero done", done, 1);
    chk("zero nv", n_v, 0);
    chk("zero busy", busy, 0);
    chk("zero en", drv_en_SM, 0);
    chk("zero cnt", step_cnt, 0);
    tick();
    chk("zero done_off", done, 0);
    chk("zero en2", drv_en_SM, 0);
    chk("zero nv2", n_v, 0);

    // MOVE, then stop and go together: stop wins
    go(2'b01, '0);
    tick();
    drv_step = 1'b1;
    tick();
    drv_step = 1'b0;
    chk("sg cnt", step_cnt, 1);
    tick();
    mode = 2'b00;
    cmd_stop = 1'b1;
    cmd_go = 1'b1;
    tick();
    cmd_stop = 1'b0;
    cmd_go = 1'b0;
    chk("sg busy", busy, 0);
    chk("sg done", done, 0);
    chk("sg en", drv_en_SM, 0);
    tick();
    chk("sg busy2", busy, 0);

    // Reserved mode changes nothing
    go(2'b11, 16'd7);
    chk("rsv busy", busy, 0);
    chk("rsv nv", n_v, 0);
    chk("rsv cnt", step_cnt, 1);
    tick();
    chk("rsv busy2", busy, 0);

    // Asynchronous reset in the middle of MOVE
    go(2'b01, '0);
    tick();
    drv_step = 1'b1;
    tick();
    drv_step = 1'b0;
    tick();
    chk("mid cnt", step_cnt, 1);
    chk("mid en", drv_en_SM, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst en", drv_en_SM, 0);
    chk("arst nv", n_v, 0);
    chk("arst busy", busy, 0);
    chk("arst n", n, P_MAX);
    chk("arst cnt", step_cnt, 0);
    chk("arst done", done, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("post busy", busy, 0);
    chk("post done", done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
